// File: rtl/ff_reg_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with valid/ready
// flow control, bubble collapsing, synchronous flush and a registered occupancy count.
module ff_reg_pipe #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             __clk,
  input  logic             __arst_n,
  input  logic [WIDTH-1:0] __reset_value,
  input  logic             __flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] rdy, move;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic             accept, consume;

  // Readiness ripples from the output stage back toward the input stage.
  always_comb begin : advance
    move = '0;
    rdy  = '0;
    move[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    rdy[DEPTH-1]  = ~v_q[DEPTH-1] | move[DEPTH-1];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      move[DEPTH-1-k] = v_q[DEPTH-1-k] & rdy[DEPTH-k];
      rdy[DEPTH-1-k]  = ~v_q[DEPTH-1-k] | move[DEPTH-1-k];
    end
  end

  assign in_ready = rdy[0] & ~__flush & ~__arst_n;
  assign accept   = in_valid & in_ready;
  assign consume  = move[DEPTH-1];

  always_comb begin : next_state
    v_d   = v_q;
    d_d   = d_q;
    occ_d = occ_q;
    if (__flush) begin
      v_d   = '0;
      occ_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_d[i] = __reset_value;
      end
    end else begin
      v_d[0] = accept | (v_q[0] & ~rdy[0]);
      if (accept) begin
        d_d[0] = in_data;
      end
      // Data registers only load when a valid item actually moves in.
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v_d[i] = move[i-1] | (v_q[i] & ~rdy[i]);
        if (move[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
      if (accept && !consume) begin
        occ_d = occ_q + CW'(1);
      end else if (!accept && consume) begin
        occ_d = occ_q - CW'(1);
      end
    end
  end

  always_ff @(posedge __clk or posedge __arst_n) begin
    if (__arst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= __reset_value;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ff_reg_pipe.sv
// Directed bench for ff_reg_pipe at DEPTH 2, 3 and 4 with a per-instance
// scoreboard queue checked whenever an item is consumed at the output.
module tb_ff_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] rv;
  logic        flush_off;
  logic        flush4;

  logic        iv2, ir2, ov2, or2;
  logic [15:0] id2, od2;
  logic [1:0]  oc2;
  logic        iv3, ir3, ov3, or3;
  logic [15:0] id3, od3;
  logic [1:0]  oc3;
  logic        iv4, ir4, ov4, or4;
  logic [15:0] id4, od4;
  logic [2:0]  oc4;

  logic [15:0] q2[$];
  logic [15:0] q3[$];
  logic [15:0] q4[$];

  int cnt_cmp  = 0;
  int cnt_fail = 0;

  ff_reg_pipe #(.WIDTH(16), .DEPTH(2)) u2 (
    .__clk(clk), .__arst_n(rst), .__reset_value(rv), .__flush(flush_off),
    .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(or2), .occupancy(oc2));

  ff_reg_pipe #(.WIDTH(16), .DEPTH(3)) u3 (
    .__clk(clk), .__arst_n(rst), .__reset_value(rv), .__flush(flush_off),
    .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(or3), .occupancy(oc3));

  ff_reg_pipe #(.WIDTH(16), .DEPTH(4)) u4 (
    .__clk(clk), .__arst_n(rst), .__reset_value(rv), .__flush(flush4),
    .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(or4), .occupancy(oc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt_cmp++;
    assert (obs === exp) else begin
      cnt_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Consumes are decided between edges; sample them on the falling edge.
  always @(negedge clk) begin
    if (ov2 === 1'b1 && or2 === 1'b1) begin
      cnt_cmp++;
      assert (q2.size() != 0) else begin
        cnt_fail++;
        $error("FAIL d2_extra: got item %0h expected none", od2);
      end
      if (q2.size() != 0) chk("d2_data", 32'(od2), 32'(q2.pop_front()));
    end
    if (ov3 === 1'b1 && or3 === 1'b1) begin
      cnt_cmp++;
      assert (q3.size() != 0) else begin
        cnt_fail++;
        $error("FAIL d3_extra: got item %0h expected none", od3);
      end
      if (q3.size() != 0) chk("d3_data", 32'(od3), 32'(q3.pop_front()));
    end
    if (ov4 === 1'b1 && or4 === 1'b1) begin
      cnt_cmp++;
      assert (q4.size() != 0) else begin
        cnt_fail++;
        $error("FAIL d4_extra: got item %0h expected none", od4);
      end
      if (q4.size() != 0) chk("d4_data", 32'(od4), 32'(q4.pop_front()));
    end
  end

  initial begin
    rst = 1'b0; rv = 16'hA5A5; flush_off = 1'b0; flush4 = 1'b0;
    iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    iv4 = 1'b0; id4 = '0; or4 = 1'b0;

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("rst_data",  32'(od2), 32'hA5A5);
    chk("rst_valid", 32'(ov2), 32'd0);
    chk("rst_occ",   32'(oc2), 32'd0);
    chk("rst_rdy",   32'(ir2), 32'd0);
    chk("rst_data4", 32'(od4), 32'hA5A5);
    step;
    step;
    rst = 1'b0;

    // Streaming through DEPTH 2
    or2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv2 = 1'b1;
      id2 = 16'(i + 1);
      #1;
      chk("str_rdy", 32'(ir2), 32'd1);
      q2.push_back(id2);
      step;
      chk("str_valid", 32'(ov2), (i >= 1) ? 32'd1 : 32'd0);
    end
    iv2 = 1'b0;
    step;
    chk("str_last_valid", 32'(ov2), 32'd1);
    step;
    chk("str_empty", 32'(ov2), 32'd0);
    chk("str_q", 32'(q2.size()), 32'd0);

    // Stall and collapse in DEPTH 4
    or4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      iv4 = 1'b1;
      id4 = 16'(i * 16'h0011);
      #1;
      chk("stl_rdy", 32'(ir4), 32'd1);
      q4.push_back(id4);
      step;
    end
    iv4 = 1'b0;
    #1;
    chk("stl_occ", 32'(oc4), 32'd4);
    chk("stl_full_rdy", 32'(ir4), 32'd0);
    chk("stl_head", 32'(od4), 32'h0011);
    or4 = 1'b1; iv4 = 1'b1; id4 = 16'h0055;
    #1;
    chk("stl_pass_rdy", 32'(ir4), 32'd1);
    q4.push_back(id4);
    step;
    or4 = 1'b0; iv4 = 1'b0;
    #1;
    chk("stl_occ_keep", 32'(oc4), 32'd4);
    chk("stl_next", 32'(od4), 32'h0022);
    or4 = 1'b1;
    repeat (4) step;
    or4 = 1'b0;
    #1;
    chk("stl_drained", 32'(oc4), 32'd0);
    chk("stl_q", 32'(q4.size()), 32'd0);

    // Bubbles in DEPTH 3
    or3 = 1'b0;
    iv3 = 1'b1; id3 = 16'h00AA;
    q3.push_back(id3);
    step;
    iv3 = 1'b0;
    step;
    step;
    iv3 = 1'b1; id3 = 16'h00BB;
    #1;
    chk("bub_rdy", 32'(ir3), 32'd1);
    q3.push_back(id3);
    step;
    iv3 = 1'b0;
    step;
    chk("bub_occ", 32'(oc3), 32'd2);
    chk("bub_head", 32'(od3), 32'h00AA);
    chk("bub_valid", 32'(ov3), 32'd1);
    chk("bub_in_rdy", 32'(ir3), 32'd1);
    or3 = 1'b1;
    repeat (3) step;
    or3 = 1'b0;
    chk("bub_q", 32'(q3.size()), 32'd0);
    chk("bub_occ0", 32'(oc3), 32'd0);

    // Flush in DEPTH 4 with three held items
    for (int i = 0; i < 3; i++) begin
      iv4 = 1'b1;
      id4 = 16'(16'h0061 + i);
      q4.push_back(id4);
      step;
    end
    chk("fl_occ3", 32'(oc4), 32'd3);
    rv = 16'h0F0F; flush4 = 1'b1; iv4 = 1'b1; id4 = 16'h0099;
    #1;
    chk("fl_rdy", 32'(ir4), 32'd0);
    step;
    q4.delete();
    flush4 = 1'b0; iv4 = 1'b0;
    chk("fl_occ", 32'(oc4), 32'd0);
    chk("fl_valid", 32'(ov4), 32'd0);
    chk("fl_data", 32'(od4), 32'h0F0F);
    step;
    chk("fl_no_accept", 32'(oc4), 32'd0);

    // Reset while full and stalled
    for (int i = 0; i < 4; i++) begin
      iv4 = 1'b1;
      id4 = 16'(16'h0071 + i);
      q4.push_back(id4);
      step;
    end
    iv4 = 1'b0;
    chk("mr_full", 32'(oc4), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", 32'(ov4), 32'd0);
    chk("mr_occ", 32'(oc4), 32'd0);
    chk("mr_rdy", 32'(ir4), 32'd0);
    chk("mr_data", 32'(od4), 32'h0F0F);
    q4.delete();
    step;
    rst = 1'b0;
    or4 = 1'b1; iv4 = 1'b1; id4 = 16'h1234;
    #1;
    chk("mr_push_rdy", 32'(ir4), 32'd1);
    q4.push_back(id4);
    step;
    iv4 = 1'b0;
    chk("mr_lat0", 32'(ov4), 32'd0);
    step;
    chk("mr_lat1", 32'(ov4), 32'd0);
    step;
    chk("mr_lat2", 32'(ov4), 32'd0);
    step;
    chk("mr_lat3", 32'(ov4), 32'd1);
    chk("mr_only", 32'(oc4), 32'd1);
    chk("mr_item", 32'(od4), 32'h1234);
    step;
    chk("mr_done_valid", 32'(ov4), 32'd0);
    chk("mr_done_occ", 32'(oc4), 32'd0);
    chk("end_q2", 32'(q2.size()), 32'd0);
    chk("end_q3", 32'(q3.size()), 32'd0);
    chk("end_q4", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
    $finish;
  end

endmodule
